// File: rtl/reg_pipe_skid_if.sv
// Valid/ready stream bundle around reg_pipe_skid: producer side, consumer side and flush.
// The slave modport is the slice; the master modport is whoever drives both ends.
interface reg_pipe_skid_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_flush;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;

    modport slave (
        input  i_flush,
        input  i_valid,
        output o_ready,
        input  i_data,
        output o_valid,
        input  i_ready,
        output o_data
    );

    modport master (
        output i_flush,
        output i_valid,
        input  o_ready,
        output i_data,
        input  o_valid,
        output i_ready,
        input  o_data
    );
endinterface

// File: rtl/reg_pipe_skid.sv
// Pipeline register slice with a two-entry skid buffer; every output decodes from flops only,
// so downstream i_ready never reaches upstream o_ready combinationally.
module reg_pipe_skid #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    reg_pipe_skid_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  ready;
    logic                  valid;
    logic                  in_fire;
    logic                  out_fire;

    assign ready    = (state_q != FULL);
    assign valid    = (state_q != EMPTY);
    assign in_fire  = bus.i_valid & ready;
    assign out_fire = valid & bus.i_ready;

    assign bus.o_ready = ready;
    assign bus.o_valid = valid;
    assign bus.o_data  = main_q;

    // State and storage registers; flush only touches state, data is left as-is
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and next-data decode
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = bus.i_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.i_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = bus.i_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifndef RTL_SYN
    logic                  stall_q;
    logic [DATA_WIDTH-1:0] stall_data_q;

    // Input sanity and producer hold rule: a stalled offer must stay put until taken or flushed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
        end else begin
            if ($isunknown({bus.i_valid, bus.i_ready, bus.i_flush}))
                $fatal(1, "reg_pipe_skid: X on i_valid/i_ready/i_flush");
            if (in_fire && $isunknown(bus.i_data))
                $fatal(1, "reg_pipe_skid: X on i_data while accepting");
            if (stall_q && !bus.i_flush && (!bus.i_valid || (bus.i_data !== stall_data_q)))
                $fatal(1, "reg_pipe_skid: producer changed a stalled payload");
            stall_q      <= bus.i_valid & ~ready & ~bus.i_flush;
            stall_data_q <= bus.i_data;
        end
    end
`endif
endmodule

// File: tb/tb_reg_pipe_skid.sv
// Directed bench for reg_pipe_skid: reset, streaming, backpressure, pass-through, flush, async reset.
module tb_reg_pipe_skid;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    reg_pipe_skid_if #(.DATA_WIDTH(32)) bus ();

    reg_pipe_skid #(.DATA_WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are settled and inputs may change 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic r, input logic [31:0] d);
        check({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
        check({tag, ".ready"}, 32'(bus.o_ready), 32'(r));
        check({tag, ".data"},  bus.o_data, d);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = 32'h0;
        bus.i_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        expect_out("reset", 1'b0, 1'b1, 32'h0);

        // Streaming at full rate
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h11; step(); expect_out("stream0", 1'b1, 1'b1, 32'h11);
        bus.i_data  = 32'h22; step(); expect_out("stream1", 1'b1, 1'b1, 32'h22);
        bus.i_data  = 32'h33; step(); expect_out("stream2", 1'b1, 1'b1, 32'h33);
        bus.i_valid = 1'b0;   step(); check("stream_drain.valid", 32'(bus.o_valid), 32'd0);

        // Backpressure fills the skid, then drains in order
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hA0; step(); expect_out("bp0", 1'b1, 1'b1, 32'hA0);
        bus.i_data  = 32'hA1; step(); expect_out("bp_full", 1'b1, 1'b0, 32'hA0);
        bus.i_valid = 1'b0;   step(); expect_out("bp_hold", 1'b1, 1'b0, 32'hA0);
        bus.i_ready = 1'b1;   step(); expect_out("bp_drain", 1'b1, 1'b1, 32'hA1);
        step(); check("bp_empty.valid", 32'(bus.o_valid), 32'd0);

        // Simultaneous accept and consume in BUSY stays BUSY
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h5; step(); expect_out("pass0", 1'b1, 1'b1, 32'h5);
        bus.i_data  = 32'h6; step(); expect_out("pass1", 1'b1, 1'b1, 32'h6);
        bus.i_valid = 1'b0;  step(); check("pass_empty.valid", 32'(bus.o_valid), 32'd0);

        // Flush from FULL drops the concurrent offer and keeps data registers
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hB0; step();
        bus.i_data  = 32'hB1; step(); expect_out("flush_pre", 1'b1, 1'b0, 32'hB0);
        bus.i_flush = 1'b1;
        bus.i_data  = 32'hB2; step(); expect_out("flush", 1'b0, 1'b1, 32'hB0);
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;   step(); expect_out("flush_after", 1'b0, 1'b1, 32'hB0);

        // Asynchronous reset while FULL, checked before the next edge
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hC0; step();
        bus.i_data  = 32'hC1; step(); expect_out("rst_pre", 1'b1, 1'b0, 32'hC0);
        bus.i_valid = 1'b0;
        #2 rst = 1'b1;
        #1 expect_out("rst_async", 1'b0, 1'b1, 32'h0);
        step();
        rst = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hD0; step(); expect_out("rst_recover", 1'b1, 1'b1, 32'hD0);
        bus.i_valid = 1'b0;   step(); check("rst_recover_empty.valid", 32'(bus.o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
